// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants for the data memory responder
// Contents: MMIO base word address, MMIO register offsets, STATUS bit positions,
//           and a helper that packs the STATUS word.
package data_memory_pkg;

    // Word address of byte address 0xFFFF_0000.
    localparam logic [29:0] MMIO_BASE_WORD = 30'h3FFF_C000;

    typedef enum logic [1:0] {
        OFF_CYCLE  = 2'd0,
        OFF_GPIO   = 2'd1,
        OFF_TXDATA = 2'd2,
        OFF_STATUS = 2'd3
    } mmio_offset_t;

    localparam int STATUS_COUNT_LSB    = 0;
    localparam int STATUS_FULL_BIT     = 3;
    localparam int STATUS_EMPTY_BIT    = 4;
    localparam int STATUS_OVERFLOW_BIT = 5;

    function automatic logic [31:0] pack_status(input logic       overflow,
                                                input logic       empty,
                                                input logic       full,
                                                input logic [2:0] count);
        logic [31:0] s;
        s = '0;
        s[STATUS_COUNT_LSB +: 3]  = count;
        s[STATUS_FULL_BIT]        = full;
        s[STATUS_EMPTY_BIT]       = empty;
        s[STATUS_OVERFLOW_BIT]    = overflow;
        return s;
    endfunction

endpackage

// File: rtl/data_memory_responder_tx_fifo.sv
// rtl/data_memory_responder_tx_fifo.sv - synchronous FIFO core without overflow tracking
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   push, push_data       write request; accepted when not full or when popping
//   pop                   read request; ignored when empty
//   head                  oldest entry, zero when empty
//   full, empty, count    occupancy (count spans 0..2**DEPTH_LOG2)
module tx_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when a pop frees the head slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word RAM plus MMIO (cycle, GPIO, TX FIFO, status) for a single-cycle CPU
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   address[29:0]                  CPU word address (byte address bits 31:2)
//   write_enable, write_input      whole-word store for this cycle
//   read_result                    combinational load data
//   gpio_out                       general-purpose output register
//   tx_data, tx_valid, tx_ready    byte stream drained from the transmit FIFO
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int DEPTH_LOG2      = 10,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] address,
    input  logic        write_enable,
    input  logic [31:0] write_input,
    output logic [31:0] read_result,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    logic [31:0]              ram [2 ** DEPTH_LOG2];
    logic [31:0]              cycle_count;
    logic                     overflow;
    logic                     ram_hit;
    logic                     mmio_hit;
    mmio_offset_t             offset;
    logic [DEPTH_LOG2-1:0]    ram_index;
    logic                     push_req;
    logic                     status_write;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    assign ram_hit      = (address[29:DEPTH_LOG2] == '0);
    assign ram_index    = address[DEPTH_LOG2-1:0];
    assign mmio_hit     = (address[29:2] == MMIO_BASE_WORD[29:2]);
    assign offset       = mmio_offset_t'(address[1:0]);
    assign push_req     = write_enable && mmio_hit && (offset == OFF_TXDATA);
    assign status_write = write_enable && mmio_hit && (offset == OFF_STATUS);
    assign pop          = tx_valid && tx_ready;
    assign tx_valid     = !fifo_empty;

    tx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (8)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (write_input[7:0]),
        .pop       (pop),
        .head      (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // RAM is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (write_enable && ram_hit) begin
            ram[ram_index] <= write_input;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count <= '0;
            gpio_out    <= '0;
            overflow    <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (write_enable && mmio_hit && (offset == OFF_GPIO)) begin
                gpio_out <= write_input;
            end
            // A rejected push outranks a simultaneous clear.
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (status_write) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        read_result = '0;
        if (ram_hit) begin
            read_result = ram[ram_index];
        end else if (mmio_hit) begin
            case (offset)
                OFF_CYCLE:  read_result = cycle_count;
                OFF_GPIO:   read_result = gpio_out;
                OFF_TXDATA: read_result = '0;
                OFF_STATUS: read_result = pack_status(overflow, fifo_empty, fifo_full,
                                                      3'(fifo_count));
                default:    read_result = '0;
            endcase
        end
    end

endmodule
